// File: rtl/mmult_seq_ctrl_if.sv
// Handshake and matrix bus for the sequenced 3x3 multiplier.
// Operands and result travel row-major, element (r,c) at slot 3r+c.
interface mmult_seq_ctrl_if;
  logic         start;
  logic [0:71]  A_mat;
  logic [0:71]  B_mat;
  logic [0:161] C_mat;
  logic         busy;
  logic         valid;

  modport master (
    output start, A_mat, B_mat,
    input  C_mat, busy, valid
  );

  modport slave (
    input  start, A_mat, B_mat,
    output C_mat, busy, valid
  );
endinterface

// File: rtl/mmult_seq_ctrl.sv
// Sequenced 3x3 unsigned matrix multiplier: one shift-add
// multiplier and one accumulator time-shared over all 27 products.
module mmult_seq_ctrl (
  input  logic              clk,
  input  logic              reset_n,
  mmult_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [0:71]  a_r;
  logic [0:71]  b_r;
  logic [0:161] c_r;
  logic [17:0]  acc;
  logic [15:0]  prod;
  logic [1:0]   i;
  logic [1:0]   j;
  logic [1:0]   k;
  logic [2:0]   b;

  logic [3:0]   a_el;
  logic [3:0]   b_el;
  logic [3:0]   c_el;
  logic [6:0]   a_off;
  logic [6:0]   b_off;
  logic [7:0]   c_off;
  logic [7:0]   mcand;
  logic [7:0]   mplier;
  logic [17:0]  sum;
  logic         last_k;
  logic         last_el;

  // Operand/result slot offsets for the current (i,j,k)
  always_comb begin
    a_el   = 4'(i) * 4'd3 + 4'(k);
    b_el   = 4'(k) * 4'd3 + 4'(j);
    c_el   = 4'(i) * 4'd3 + 4'(j);
    a_off  = 7'({3'b000, a_el} << 3);
    b_off  = 7'({3'b000, b_el} << 3);
    c_off  = 8'(c_el) * 8'd18;
    mcand  = a_r[a_off +: 8];
    mplier = b_r[b_off +: 8];
    sum    = acc + {2'b00, prod};
    last_k = (k == 2'd2);
    last_el = last_k && (i == 2'd2) && (j == 2'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = MUL;
      MUL:  if (b == 3'd7) state_nxt = ACC;
      ACC:  state_nxt = last_el ? DONE : MUL;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= '0;
      acc  <= '0;
      prod <= '0;
      i    <= '0;
      j    <= '0;
      k    <= '0;
      b    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_r  <= bus.A_mat;
            b_r  <= bus.B_mat;
            c_r  <= '0;
            acc  <= '0;
            prod <= '0;
            i    <= '0;
            j    <= '0;
            k    <= '0;
            b    <= '0;
          end
        end
        MUL: begin
          if (mplier[b]) begin
            prod <= prod + ({8'h00, mcand} << b);
          end
          b <= b + 3'd1;
        end
        ACC: begin
          prod <= '0;
          b    <= '0;
          if (!last_k) begin
            acc <= sum;
            k   <= k + 2'd1;
          end else begin
            c_r[c_off +: 18] <= sum;
            acc <= '0;
            k   <= '0;
            // Row-major walk: j first, wrap into next row
            if (j == 2'd2) begin
              j <= '0;
              i <= i + 2'd1;
            end else begin
              j <= j + 2'd1;
            end
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign bus.C_mat = c_r;
  assign bus.busy  = (state != IDLE);
  assign bus.valid = (state == DONE);

endmodule

// File: tb/tb_mmult_seq_ctrl.sv
// Randomized bench for mmult_seq_ctrl against a plain
// triple-loop matrix product with edge-accurate timing.
module tb_mmult_seq_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  mmult_seq_ctrl_if ia ();

  mmult_seq_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ia.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [161:0] obs,
                       input logic [161:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:161] model(input logic [0:71] a,
                                         input logic [0:71] b);
    logic [0:161] c;
    int s;
    c = '0;
    for (int r = 0; r < 3; r++) begin
      for (int cc = 0; cc < 3; cc++) begin
        s = 0;
        for (int t = 0; t < 3; t++)
          s += int'(a[(3*r+t)*8 +: 8]) * int'(b[(3*t+cc)*8 +: 8]);
        c[(3*r+cc)*18 +: 18] = 18'(s);
      end
    end
    return c;
  endfunction

  // Result as visible after edge e: element n lands at edge 27(n+1)
  function automatic logic [0:161] upto(input logic [0:161] c,
                                        input int e);
    logic [0:161] v;
    v = c;
    for (int n = 0; n < 9; n++)
      if (27 * (n + 1) > e) v[n*18 +: 18] = '0;
    return v;
  endfunction

  function automatic logic [17:0] el(input logic [0:161] c,
                                     input int n);
    return c[n*18 +: 18];
  endfunction

  function automatic logic [0:71] seq(input int base, input int step);
    logic [0:71] m;
    for (int n = 0; n < 9; n++) m[n*8 +: 8] = 8'(base + step * n);
    return m;
  endfunction

  function automatic logic [0:71] ident();
    logic [0:71] m;
    m = '0;
    for (int n = 0; n < 3; n++) m[(4*n)*8 +: 8] = 8'd1;
    return m;
  endfunction

  function automatic logic [0:71] rnd();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w[71:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input string tag,
                     input logic [0:71] a,
                     input logic [0:71] b,
                     input bit perturb,
                     input bit hold,
                     output logic [0:161] res);
    logic [0:161] exp;
    logic [0:161] pv;
    int vcnt;
    int berr;
    int verr;
    int perr;
    bit bexp;
    exp = model(a, b);
    @(negedge clk);
    ia.A_mat = a;
    ia.B_mat = b;
    ia.start = 1'b1;
    @(posedge clk);
    #1;
    ia.start = hold;
    vcnt = 0; berr = 0; verr = 0; perr = 0;
    for (int e = 1; e <= 245; e++) begin
      @(posedge clk);
      #1;
      bexp = (e < 244) || (hold && e == 245);
      pv = (hold && e == 245) ? '0 : upto(exp, e);
      if (ia.busy !== bexp) berr++;
      if (ia.valid !== (e == 243)) verr++;
      if (ia.valid === 1'b1) vcnt++;
      if (ia.C_mat !== pv) perr++;
      if (e == 27) check({tag, " c00@27"}, 162'(el(ia.C_mat, 0)),
                         162'(el(exp, 0)));
      if (e == 243) begin
        check({tag, " result"}, ia.C_mat, exp);
        res = ia.C_mat;
      end
      if (perturb && (e == 5 || e == 100)) begin
        ia.A_mat = rnd();
        ia.B_mat = rnd();
        ia.start = 1'b1;
      end else if (!hold) begin
        ia.start = 1'b0;
      end
    end
    check({tag, " busy-timing"}, 162'(berr), 162'(0));
    check({tag, " valid-timing"}, 162'(verr), 162'(0));
    check({tag, " valid-count"}, 162'(vcnt), 162'(1));
    check({tag, " progressive"}, 162'(perr), 162'(0));
    ia.start = 1'b0;
    if (hold) do_reset();
  endtask

  initial begin
    logic [0:161] res;
    checks = 0;
    errors = 0;
    ia.start = 1'b0;
    ia.A_mat = '0;
    ia.B_mat = '0;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst busy", 162'(ia.busy), 162'(0));
    check("rst valid", 162'(ia.valid), 162'(0));
    check("rst cmat", ia.C_mat, '0);
    do_reset();

    run("ident", ident(), seq(1, 1), 1'b0, 1'b0, res);
    check("ident vals", res, model(ident(), seq(1, 1)));

    run("mixed", seq(1, 1), seq(9, -1), 1'b0, 1'b0, res);
    check("mixed c00", 162'(el(res, 0)), 162'(30));
    check("mixed c12", 162'(el(res, 5)), 162'(54));
    check("mixed c22", 162'(el(res, 8)), 162'(90));

    run("max", seq(255, 0), seq(255, 0), 1'b0, 1'b0, res);
    for (int n = 0; n < 9; n += 4)
      check("max el", 162'(el(res, n)), 162'(18'h2FA03));

    run("ignore", seq(3, 2), seq(200, -7), 1'b1, 1'b0, res);

    for (int t = 0; t < 3; t++)
      run("random", rnd(), rnd(), 1'b0, 1'b0, res);

    run("hold", rnd(), rnd(), 1'b0, 1'b1, res);

    @(negedge clk);
    ia.A_mat = seq(7, 5);
    ia.B_mat = seq(11, 3);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    repeat (118) @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst busy", 162'(ia.busy), 162'(0));
    check("midrst valid", 162'(ia.valid), 162'(0));
    check("midrst cmat", ia.C_mat, '0);
    @(negedge clk);
    reset_n = 1'b1;
    run("restart", ident(), ident(), 1'b0, 1'b0, res);
    check("restart ident", res, 162'(ident()) == '0 ? '1 :
          model(ident(), ident()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
